// File: rtl/shift_reg_seq_pkg.sv
// Shared types for the shift-register command sequencer: op codes, register
// mode encodings, FSM states and the latched command payload.
package shift_reg_seq_pkg;

    localparam int unsigned SR_W     = 4;
    localparam int unsigned SR_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_LOAD_ONLY   = 2'b00,
        OP_LOAD_SHIFT  = 2'b01,
        OP_LOAD_ROTATE = 2'b10,
        OP_SHIFT_ONLY  = 2'b11
    } cmd_op_e;

    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;
    localparam logic [1:0] MODO_LOAD   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    typedef struct packed {
        cmd_op_e         op;
        logic            dir;
        logic            sin;
        logic [SR_W-1:0] data;
    } cmd_t;

    // Register mode used while stepping; only LOAD_ROTATE rotates.
    function automatic logic [1:0] run_modo(input cmd_op_e op);
        return (op == OP_LOAD_ROTATE) ? MODO_ROTATE : MODO_SHIFT;
    endfunction

endpackage

// File: rtl/shift_reg_step_counter.sv
// Loadable down-counter tracking the remaining shift/rotate steps of a command.
module shift_reg_step_counter
    import shift_reg_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SR_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic [SR_CNT_W-1:0] count,
    output logic                zero_c
);

    logic [SR_CNT_W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - SR_CNT_W'(1);
        end
    end

    assign count  = cnt;
    assign zero_c = (cnt == '0);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for a 4-bit universal shift register: load, then
// N shifts or rotations, then return the final Q/S_OUT on a response port.
module shift_reg_sequencer
    import shift_reg_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic                cmd_dir,
    input  logic                cmd_sin,
    input  logic [SR_W-1:0]     cmd_data,
    input  logic [SR_CNT_W-1:0] cmd_count,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_W-1:0]     rsp_q,
    output logic                rsp_sout,
    output logic                enb,
    output logic                dir,
    output logic                s_in,
    output logic [1:0]          modo,
    output logic [SR_W-1:0]     d,
    input  logic [SR_W-1:0]     q,
    input  logic                s_out
);

    state_e              state, state_d;
    cmd_t                cmd_q, cmd_cur;
    logic                accept;
    logic                step_dec;
    logic [SR_CNT_W-1:0] step_cnt;
    logic                step_zero_c;

    logic                cmd_ready_d, rsp_valid_d, enb_d, dir_d, s_in_d;
    logic [1:0]          modo_d;
    logic [SR_W-1:0]     d_d;

    assign accept   = cmd_valid && cmd_ready;
    assign step_dec = (state == ST_RUN);

    shift_reg_step_counter u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cmd_count),
        .dec      (step_dec),
        .count    (step_cnt),
        .zero_c   (step_zero_c)
    );

    // Next state plus next-cycle pin values, so the pins line up with the state they belong to.
    always_comb begin
        state_d     = state;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        enb_d       = 1'b0;
        dir_d       = 1'b0;
        s_in_d      = 1'b0;
        modo_d      = MODO_SHIFT;
        d_d         = '0;

        cmd_cur = cmd_q;
        if (accept) begin
            cmd_cur.op   = cmd_op_e'(cmd_op);
            cmd_cur.dir  = cmd_dir;
            cmd_cur.sin  = cmd_sin;
            cmd_cur.data = cmd_data;
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_cur.op == OP_SHIFT_ONLY) begin
                        state_d = (cmd_count == '0) ? ST_CAPTURE : ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ((cmd_cur.op == OP_LOAD_ONLY) || step_zero_c) ? ST_CAPTURE : ST_RUN;
            end
            ST_RUN: begin
                if (step_cnt == SR_CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_LOAD: begin
                enb_d  = 1'b1;
                modo_d = MODO_LOAD;
                d_d    = cmd_cur.data;
            end
            ST_RUN: begin
                enb_d  = 1'b1;
                dir_d  = cmd_cur.dir;
                modo_d = run_modo(cmd_cur.op);
                s_in_d = (modo_d == MODO_SHIFT) ? cmd_cur.sin : 1'b0;
            end
            ST_RESP: rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    // State, registered pins, command latch and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_sout  <= 1'b0;
            enb       <= 1'b0;
            dir       <= 1'b0;
            s_in      <= 1'b0;
            modo      <= MODO_SHIFT;
            d         <= '0;
        end else begin
            state     <= state_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            enb       <= enb_d;
            dir       <= dir_d;
            s_in      <= s_in_d;
            modo      <= modo_d;
            d         <= d_d;
            if (accept) begin
                cmd_q <= cmd_cur;
            end
            if (state == ST_CAPTURE) begin
                rsp_q    <= q;
                rsp_sout <= s_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit universal shift register.
module tb_shift_reg_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic       cmd_sin;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_q;
    logic       rsp_sout;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       s_out;

    int tests;
    int fails;

    shift_reg_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_sin   (cmd_sin),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_sout  (rsp_sout),
        .enb       (enb),
        .dir       (dir),
        .s_in      (s_in),
        .modo      (modo),
        .d         (d),
        .q         (q),
        .s_out     (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register: DIR=1 right, S_OUT holds the last bit shifted out.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= 4'b0000;
            s_out <= 1'b0;
        end else if (enb) begin
            case (modo)
                2'b10: q <= d;
                2'b00: begin
                    if (dir) begin
                        q <= {s_in, q[3:1]};
                        s_out <= q[0];
                    end else begin
                        q <= {q[2:0], s_in};
                        s_out <= q[3];
                    end
                end
                2'b01: begin
                    if (dir) begin
                        q <= {q[0], q[3:1]};
                        s_out <= q[0];
                    end else begin
                        q <= {q[2:0], q[3]};
                        s_out <= q[3];
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure latency/ENB cycles, optionally stall the response, then consume it.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic dir_i,
                           input logic sin_i, input logic [3:0] data, input logic [3:0] cnt,
                           input int exp_q, input int exp_sout, input int exp_lat,
                           input int exp_enb, input int hold);
        int lat;
        int enb_cycles;
        int bad_modo;
        int stray;
        lat = 0;
        enb_cycles = 0;
        bad_modo = 0;
        stray = 0;
        @(negedge clk);
        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir_i;
        cmd_sin   = sin_i;
        cmd_data  = data;
        cmd_count = cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (enb) enb_cycles++;
            if (modo == 2'b11) bad_modo++;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".enb_cycles"}, 32'(enb_cycles), 32'(exp_enb));
        check({tag, ".modo11"}, 32'(bad_modo), 0);
        check({tag, ".rsp_q"}, 32'(rsp_q), 32'(exp_q));
        check({tag, ".rsp_sout"}, 32'(rsp_sout), 32'(exp_sout));
        check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_op    = 2'b00;
            cmd_data  = 4'b0000;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 1);
            check({tag, ".hold_q"}, 32'(rsp_q), 32'(exp_q));
            check({tag, ".hold_ready"}, 32'(cmd_ready), 0);
            check({tag, ".hold_enb"}, 32'(enb), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".rsp_done"}, 32'(rsp_valid), 0);
        check({tag, ".back_idle"}, 32'(cmd_ready), 1);
        if (hold > 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (enb || rsp_valid || !cmd_ready) stray++;
            end
            check({tag, ".no_stray_cmd"}, 32'(stray), 0);
        end
    endtask

    initial begin
        int stray;
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_dir   = 1'b0;
        cmd_sin   = 1'b0;
        cmd_data  = 4'b0000;
        cmd_count = 4'd0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.cmd_ready", 32'(cmd_ready), 1);
        check("rst.rsp_valid", 32'(rsp_valid), 0);
        check("rst.enb", 32'(enb), 0);
        check("rst.modo", 32'(modo), 0);
        check("rst.d", 32'(d), 0);
        check("rst.rsp_q", 32'(rsp_q), 0);
        check("rst.rsp_sout", 32'(rsp_sout), 0);
        reset = 1'b0;

        //       tag     op     dir   sin   data     cnt    q    sout lat enb hold
        run_cmd("t1a", 2'b10, 1'b1, 1'b0, 4'b0001, 4'd1,  'h8, 1,   4,  2,  0);
        run_cmd("t1b", 2'b10, 1'b1, 1'b0, 4'b0001, 4'd4,  'h1, 0,   7,  5,  0);
        run_cmd("t2a", 2'b10, 1'b0, 1'b0, 4'b1000, 4'd1,  'h1, 1,   4,  2,  0);
        run_cmd("t2b", 2'b01, 1'b1, 1'b0, 4'b1011, 4'd2,  'h2, 1,   5,  3,  0);
        run_cmd("t3a", 2'b00, 1'b0, 1'b0, 4'b0110, 4'd5,  'h6, 1,   3,  1,  0);
        run_cmd("t3b", 2'b11, 1'b0, 1'b1, 4'b0000, 4'd1,  'hD, 0,   3,  1,  0);
        run_cmd("t4a", 2'b01, 1'b1, 1'b1, 4'b1010, 4'd0,  'hA, 0,   3,  1,  0);
        run_cmd("t4b", 2'b10, 1'b1, 1'b0, 4'b0001, 4'd15, 'h2, 0,   18, 16, 0);
        run_cmd("t4c", 2'b11, 1'b1, 1'b1, 4'b1111, 4'd0,  'h2, 0,   2,  0,  0);
        run_cmd("t5",  2'b01, 1'b0, 1'b0, 4'b1111, 4'd1,  'hE, 1,   4,  2,  5);

        // Reset in the middle of a long rotate: pins drop at once and no response follows.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_dir   = 1'b1;
        cmd_data  = 4'b0101;
        cmd_count = 4'd8;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6.in_run_enb", 32'(enb), 1);
        check("t6.in_run_modo", 32'(modo), 1);
        reset = 1'b1;
        #1;
        check("t6.rst_enb", 32'(enb), 0);
        check("t6.rst_rsp_valid", 32'(rsp_valid), 0);
        check("t6.rst_cmd_ready", 32'(cmd_ready), 1);
        check("t6.rst_modo", 32'(modo), 0);
        check("t6.rst_dir", 32'(dir), 0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid || enb || !cmd_ready) stray++;
        end
        check("t6.no_response", 32'(stray), 0);
        run_cmd("t6r", 2'b00, 1'b0, 1'b0, 4'b1001, 4'd3,  'h9, 0,   3,  1,  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
